// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
//   state_t : controller FSM states
//   fp32_t  : binary32 field view {sign, exp, frac}
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [9:0]  FP_BIAS    = 10'd127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_mul_special.sv
// Combinational operand classification for the binary32 multiplier.
// Ports:
//   a, b     : binary32 operands
//   is_nan   : result is the canonical quiet NaN (NaN operand or inf x zero)
//   is_inf   : either operand is infinity
//   is_zero  : either operand has exp==0 (denormals count as zero)
//   byp_y    : bypass result, valid whenever any of the three flags is set
import fp_pkg::*;

module fp_mul_special (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic [31:0] byp_y
);

  fp32_t fa, fb;
  logic  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;

  assign fa = a;
  assign fb = b;

  assign a_nan  = (fa.exp == FP_EXP_MAX) && (fa.frac != '0);
  assign b_nan  = (fb.exp == FP_EXP_MAX) && (fb.frac != '0);
  assign a_inf  = (fa.exp == FP_EXP_MAX) && (fa.frac == '0);
  assign b_inf  = (fb.exp == FP_EXP_MAX) && (fb.frac == '0);
  assign a_zero = (fa.exp == '0);
  assign b_zero = (fb.exp == '0);
  assign sgn    = fa.sign ^ fb.sign;

  assign is_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign is_inf  = a_inf | b_inf;
  assign is_zero = a_zero | b_zero;

  // Priority: NaN beats inf beats zero.
  always_comb begin
    byp_y = {sgn, 31'h0};
    if (is_nan)      byp_y = FP_QNAN;
    else if (is_inf) byp_y = {sgn, FP_EXP_MAX, 23'h0};
  end

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequential binary32 multiplier: 24-step shift-add mantissa product, then
// normalise, round and pack. Zero/inf/NaN operands bypass the iteration.
// Optional macro FPMUL_RNE_EN selects round-to-nearest-even; otherwise the
// result is truncated.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b                : binary32 operands
//   out_valid/out_ready : result handshake (valid only in DONE)
//   y, ovf, unf         : product and overflow/underflow flags, held in DONE
import fp_pkg::*;

module fp_mul_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf
);

  state_t state, state_nx;

  fp32_t              fa, fb;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        ma_q, mb_q;
  logic [47:0]        prod_q;
  logic [4:0]         cnt_q;

  logic               is_nan, is_inf, is_zero, byp;
  logic [31:0]        byp_y;

  assign fa = a;
  assign fb = b;

  fp_mul_special u_special (
    .a       (a),
    .b       (b),
    .is_nan  (is_nan),
    .is_inf  (is_inf),
    .is_zero (is_zero),
    .byp_y   (byp_y)
  );

  assign byp       = is_nan | is_inf | is_zero;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = byp ? DONE : MUL;
      MUL:  if (cnt_q == 5'd23) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- normalise / round ----------------
  logic [22:0]       mant_raw;
  logic              guard, sticky, rnd_inc;
  logic [23:0]       mant_sum;
  logic signed [9:0] exp_n, exp_f;
  logic [31:0]       norm_y;
  logic              norm_ovf, norm_unf;

  // Product of two [1,2) mantissas lies in [1,4): bit 47 set means the
  // binary point moves one place, so take the field one bit higher.
  always_comb begin
    if (prod_q[47]) begin
      mant_raw = prod_q[46:24];
      guard    = prod_q[23];
      sticky   = |prod_q[22:0];
      exp_n    = exp_q + 10'sd1;
    end else begin
      mant_raw = prod_q[45:23];
      guard    = prod_q[22];
      sticky   = |prod_q[21:0];
      exp_n    = exp_q;
    end
  end

`ifdef FPMUL_RNE_EN
  assign rnd_inc = guard & (sticky | mant_raw[0]);
`else
  logic unused_rnd;
  assign unused_rnd = guard ^ sticky;
  assign rnd_inc    = 1'b0;
`endif

  // A carry out leaves the low 23 bits at zero, which is the required
  // mantissa; only the exponent needs the bump.
  assign mant_sum = {1'b0, mant_raw} + {23'b0, rnd_inc};
  assign exp_f    = exp_n + signed'({9'b0, mant_sum[23]});

  always_comb begin
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    norm_y   = {sign_q, exp_f[7:0], mant_sum[22:0]};
    if (exp_f >= signed'({2'b00, FP_EXP_MAX})) begin
      norm_ovf = 1'b1;
      norm_y   = {sign_q, FP_EXP_MAX, 23'h0};
    end else if (exp_f <= 10'sd0) begin
      norm_unf = 1'b1;
      norm_y   = {sign_q, 31'h0};
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      y      <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= fa.sign ^ fb.sign;
          // 10-bit wrap is two's-complement, so unsigned math is exact here
          exp_q  <= signed'({2'b00, fa.exp} + {2'b00, fb.exp} - FP_BIAS);
          ma_q   <= {1'b1, fa.frac};
          mb_q   <= {1'b1, fb.frac};
          prod_q <= '0;
          cnt_q  <= '0;
          if (byp) begin
            y   <= byp_y;
            ovf <= 1'b0;
            unf <= 1'b0;
          end
        end
        MUL: begin
          if (mb_q[cnt_q]) prod_q <= prod_q + ({24'b0, ma_q} << cnt_q);
          if (cnt_q != 5'd23) cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
          y   <= norm_y;
          ovf <= norm_ovf;
          unf <= norm_unf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
module tb_fp_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, ovf, unf;
  logic [31:0] a, b, y;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_mul_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product of the significands, then rounding
  // decided by comparing the discarded remainder against one half ulp.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] z,
                                  output logic [31:0] ry, output logic ro,
                                  output logic ru, output logic rs);
    int ex, ez, e, sh;
    logic s;
    bit xn, zn, xi, zi, x0, z0;
    longint unsigned p, m;
    ex = int'(x[30:23]);
    ez = int'(z[30:23]);
    s  = x[31] ^ z[31];
    xn = (ex == 255) && (x[22:0] != 0);
    zn = (ez == 255) && (z[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    zi = (ez == 255) && (z[22:0] == 0);
    x0 = (ex == 0);
    z0 = (ez == 0);
    ro = 1'b0; ru = 1'b0; rs = 1'b1;
    if (xn || zn || (xi && z0) || (zi && x0)) begin ry = 32'h7FC00000; return; end
    if (xi || zi) begin ry = {s, 8'hFF, 23'h0}; return; end
    if (x0 || z0) begin ry = {s, 31'h0}; return; end
    rs = 1'b0;
    p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, z[22:0]});
    e  = ex + ez - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    m = p >> sh;
`ifdef FPMUL_RNE_EN
    begin
      longint unsigned rem, half;
      rem  = p - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m++;
    end
`endif
    if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
    if (e >= 255)    begin ry = {s, 8'hFF, 23'h0}; ro = 1'b1; end
    else if (e <= 0) begin ry = {s, 31'h0}; ru = 1'b1; end
    else             ry = {s, e[7:0], m[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] opa, input logic [31:0] opb,
                        input int hold, input string tag);
    logic [31:0] ey;
    logic        eo, eu, es;
    int          lat;
    ref_mul(opa, opb, ey, eo, eu, es);
    @(negedge clk);
    chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    a = opa; b = opb; in_valid = 1'b1;
    @(posedge clk); #1;
    // Garbage requests while busy must be ignored.
    a = $urandom; b = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    chk({tag, ":latency"}, 32'(lat), es ? 32'd1 : 32'd26);
    chk({tag, ":y"}, y, ey);
    chk({tag, ":ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ":unf"}, 32'(unf), 32'(eu));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold_y"}, y, ey);
      chk({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ":post_ready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0: e = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
      1: e = 8'($urandom_range(200, 254));
      2: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e,
            ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:y", y, 32'h0);
    chk("rst:ovf", 32'(ovf), 32'd0);
    chk("rst:unf", 32'(unf), 32'd0);
    rst = 1'b0;

    run_op(32'h40000000, 32'h40400000, 0, "2x3");
    chk("2x3:const", y, 32'h40C00000);
    run_op(32'h3FC00000, 32'h3FC00000, 0, "1.5sq");
    chk("1.5sq:const", y, 32'h40100000);
    run_op(32'h3F800001, 32'h3FC00000, 0, "round");
`ifdef FPMUL_RNE_EN
    chk("round:const", y, 32'h3FC00002);
`else
    chk("round:const", y, 32'h3FC00001);
`endif
    run_op(32'h7F000000, 32'h40000000, 0, "ovf");
    chk("ovf:const", {y[31:1], ovf}, {31'h3FC00000, 1'b1});
    run_op(32'h00800000, 32'h00800000, 0, "unf");
    chk("unf:const", {y[31:1], unf}, {31'h0, 1'b1});
    run_op(32'h7F800000, 32'h00000000, 0, "infx0");
    chk("infx0:const", y, 32'h7FC00000);
    run_op(32'hC0000000, 32'h3F800000, 10, "backpressure");

    // Reset in the middle of the iteration.
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst:in_ready", 32'(in_ready), 32'd1);
    chk("midrst:out_valid", 32'(out_valid), 32'd0);
    chk("midrst:y", y, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++)
      run_op(rand_fp(), rand_fp(), int'($urandom_range(0, 2)), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
